// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and host-transmit state encoding shared by the PS/2 blocks.
package ps2_pkg;

  // Default timing, assuming a 100 MHz system clock.
  localparam int unsigned DEF_INHIBIT_CYC = 12000;    // 120 us clock inhibit before the start bit
  localparam int unsigned DEF_TIMEOUT_CYC = 2000000;  // 20 ms limit for a whole host-to-device transfer
  localparam int unsigned DEF_FILT_LEN    = 8;        // stable samples needed to accept a PS/2 clock level

  // Host-to-device transmit FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // PS/2 frames carry odd parity: the 8 data bits plus parity always hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 clock and data pads into the clk domain,
// debounces the clock line and produces a one-cycle strobe on each clock fall.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst,          // asynchronous, active low
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_filt,     // debounced PS/2 clock level
  output logic data_sync,    // synchronised PS/2 data level
  output logic fall          // one-cycle strobe when clk_filt goes 1 -> 0
);

  localparam int unsigned    CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  FILT_MAX = CW'(FILT_LEN - 1);

  logic [1:0]    clk_sync_q,  clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_filt_q,  clk_filt_d;
  logic [CW-1:0] filt_cnt_q,  filt_cnt_d;
  logic          fall_q,      fall_d;

  // Two-flop synchronisers, clock-level filter and falling-edge detection
  always_comb begin
    // NOTE: every signal written here gets a value on every path (defaults first), so no latch is inferred.
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_filt_d  = clk_filt_q;
    filt_cnt_d  = '0;
    // The filtered level only follows the synchronised clock after FILT_LEN
    // consecutive samples disagree with it; any agreeing sample restarts the run.
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall_d = clk_filt_q & ~clk_filt_d;
  end

  // Synchroniser, filter and strobe registers
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      // NOTE: these flops reset to 1 (the idle bus level), not 0, so leaving reset can never look like a clock fall.
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_filt  = clk_filt_q;
  assign data_sync = data_sync_q[1];
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device
// (request-to-send inhibit, start bit, 8 data bits LSB first, odd parity,
// stop bit, device ack), with an overall transfer timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active low
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,   // 1 = pull PS/2 clock low
  output logic       ps2_data_oe   // 1 = pull PS/2 data low
);

  localparam int unsigned   IW       = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned   FW       = $clog2(FILT_LEN + 1);
  localparam logic [IW-1:0] INH_MAX  = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [FW-1:0] IDLE_MAX = FW'(FILT_LEN - 1);
  localparam logic [3:0]    BIT_PAR  = 4'd8;   // bit_cnt value at the fall that drives parity
  localparam logic [3:0]    BIT_STOP = 4'd9;   // bit_cnt value at the fall that releases data (stop bit)

  ps2_tx_state_e state_q, state_d;

  logic [7:0]    data_q,     data_d;
  logic          parity_q,   parity_d;
  logic [IW-1:0] inh_cnt_q,  inh_cnt_d;
  logic [TW-1:0] to_cnt_q,   to_cnt_d;
  logic [FW-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]    bit_cnt_q,  bit_cnt_d;
  logic          drv_q,      drv_d;      // 1 = hold data low while in SHIFT
  logic          ack_q,      ack_d;
  logic          done_q,     done_d;
  logic          err_q,      err_d;

  logic clk_filt;
  logic data_sync;
  logic fall;
  logic bus_high;
  logic timeout;

  ps2_line_sync #(
    .FILT_LEN (FILT_LEN)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_filt    (clk_filt),
    .data_sync   (data_sync),
    .fall        (fall)
  );

  assign bus_high = clk_filt & data_sync;
  // to_cnt_q holds the number of cycles elapsed since acceptance, so the limit
  // is reached after TIMEOUT_CYC cycles whatever state the transfer is in.
  assign timeout  = (state_q != ST_IDLE) && (to_cnt_q == TO_MAX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the timeout overrides every other transition
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (tx_valid) state_d = ST_INHIBIT;
        ST_INHIBIT:   if (inh_cnt_q == INH_MAX) state_d = ST_START;
        ST_START:     state_d = ST_SHIFT;
        ST_SHIFT:     if (fall && bit_cnt_q == BIT_STOP) state_d = ST_ACK;
        ST_ACK:       if (fall) state_d = ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (bus_high && idle_cnt_q == IDLE_MAX) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: byte capture, counters, bit driver, ack flag and result pulses
  always_comb begin
    data_d     = data_q;
    parity_d   = parity_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    idle_cnt_d = idle_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    drv_d      = drv_q;
    ack_d      = ack_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q != ST_IDLE) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (timeout) begin
      // Abandon the transfer: release the data line and clear all counters.
      to_cnt_d   = '0;
      inh_cnt_d  = '0;
      idle_cnt_d = '0;
      bit_cnt_d  = '0;
      drv_d      = 1'b0;
      ack_d      = 1'b0;
      err_d      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            data_d     = tx_data;
            parity_d   = odd_parity(tx_data);
            to_cnt_d   = TW'(1);
            inh_cnt_d  = '0;
            idle_cnt_d = '0;
            bit_cnt_d  = '0;
            drv_d      = 1'b0;
            ack_d      = 1'b0;
          end
        end
        ST_INHIBIT: begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
        ST_START: begin
          // Keep the start bit on the line until the device clocks the first fall.
          drv_d     = 1'b1;
          bit_cnt_d = '0;
        end
        ST_SHIFT: begin
          if (fall) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q < BIT_PAR) begin
              drv_d = ~data_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == BIT_PAR) begin
              drv_d = ~parity_q;
            end else begin
              drv_d = 1'b0;
            end
          end
        end
        ST_ACK: begin
          if (fall) begin
            // The device acknowledges by holding data low across the eleventh fall.
            ack_d      = ~data_sync;
            err_d      = data_sync;
            idle_cnt_d = '0;
          end
        end
        ST_WAIT_IDLE: begin
          if (bus_high) begin
            if (idle_cnt_q == IDLE_MAX) begin
              done_d     = ack_q;
              to_cnt_d   = '0;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
        default: begin
          drv_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      idle_cnt_q <= '0;
      bit_cnt_q  <= '0;
      drv_q      <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      parity_q   <= parity_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      drv_q      <= drv_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Outputs decoded from the state so reset releases the pads immediately
  always_comb begin
    tx_ready    = (state_q == ST_IDLE);
    tx_busy     = (state_q != ST_IDLE);
    ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_START);
    ps2_data_oe = (state_q == ST_START) || ((state_q == ST_SHIFT) && drv_q);
    tx_done     = done_q;
    tx_err      = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model
// on an open-drain (wired-AND) bus. Short timing parameters keep runs small.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 200;
  localparam int unsigned TO   = 3000;
  localparam int unsigned FL   = 4;
  localparam int          HALF = 40;   // device clock half period in clk cycles

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data, glitch;

  int   n_checks, n_errors;
  int   done_cnt, err_cnt, both_cnt, acc_cnt;
  logic busy_prev;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TO),
    .FILT_LEN    (FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse and acceptance monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (tx_busy && !busy_prev) acc_cnt++;
    busy_prev = tx_busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < int'(TO)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_ready), 32'd1);
  endtask

  // Present one request at a negedge; it is accepted on the following posedge.
  task automatic send_req(input logic [7:0] b);
    wait_ready("ready_before_send");
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock n_falls falls, sample the
  // bus during each low phase (bits[0..9] = data0..7, parity, stop), and on
  // fall 11 hold data low when do_ack is set. A 2 ns clock glitch can be
  // injected in the high phase after fall glitch_after.
  task automatic dev_receive(input bit do_ack, input int n_falls, input int glitch_after,
                             output logic [9:0] bits);
    int n;
    bits = '0;
    n    = 0;
    @(negedge clk);
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < int'(TO)) begin
      @(negedge clk);
      n++;
    end
    check("dev_rts_seen", 32'(n < int'(TO)), 32'd1);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 11 && do_ack) begin
        dev_data = 1'b0;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i <= 10) bits[i-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
      if (i == glitch_after) begin
        repeat (10) @(negedge clk);
        #4 glitch = 1'b1;
        #2 glitch = 1'b0;
        repeat (HALF - 10) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [9:0] bits, bits2;
    int n, d0, e0, a0;

    n_checks = 0; n_errors = 0;
    done_cnt = 0; err_cnt = 0; both_cnt = 0; acc_cnt = 0; busy_prev = 1'b0;
    rst = 1'b0; tx_data = '0; tx_valid = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1; glitch = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_pulses", 32'(done_cnt + err_cnt), 32'd0);

    // 0xED with ack: bits 1,0,1,1,0,1,1,1, parity 1, stop released
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_req(8'hED);
      dev_receive(1'b1, 11, 0, bits);
    join
    wait_ready("ed_ready_after");
    repeat (3) @(negedge clk);
    check("ed_frame_bits", 32'(bits), 32'h3ED);
    check("ed_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("ed_err_pulses", 32'(err_cnt - e0), 32'd0);

    // 0xF4: parity 0, exact inhibit length then the start bit
    d0 = done_cnt;
    send_req(8'hF4);
    fork
      begin
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < int'(INH) + 10) begin
          n++;
          @(negedge clk);
        end
        check("f4_inhibit_len", 32'(n), 32'(INH));
        check("f4_start_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("f4_start_data_oe", 32'(ps2_data_oe), 32'd1);
        @(negedge clk);
        check("f4_shift_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("f4_shift_data_oe", 32'(ps2_data_oe), 32'd1);
      end
      dev_receive(1'b1, 11, 0, bits);
    join
    wait_ready("f4_ready_after");
    repeat (3) @(negedge clk);
    check("f4_frame_bits", 32'(bits), 32'h2F4);
    check("f4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // No ack on fall 11: one tx_err, no tx_done, back to IDLE once the bus idles
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_req(8'h01);
      dev_receive(1'b0, 11, 0, bits);
    join
    wait_ready("nack_ready_after");
    repeat (3) @(negedge clk);
    check("nack_frame_bits", 32'(bits), 32'h201);
    check("nack_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("nack_done_pulses", 32'(done_cnt - d0), 32'd0);

    // Device never clocks: tx_err exactly TO cycles after acceptance
    wait_ready("to_ready_before");
    d0 = done_cnt; e0 = err_cnt;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    n = 0;
    while (tx_err !== 1'b1 && n < int'(TO) + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_cycles", 32'(n), 32'(TO));
    check("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("to_data_oe", 32'(ps2_data_oe), 32'd0);
    check("to_ready", 32'(tx_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("to_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("to_done_pulses", 32'(done_cnt - d0), 32'd0);

    // Reset after fall 5 of 0x00 (data held low), then 0xFF completes normally
    fork
      send_req(8'h00);
      dev_receive(1'b1, 5, 0, bits);
    join
    check("mid_pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_req(8'hFF);
      dev_receive(1'b1, 11, 0, bits);
    join
    wait_ready("ff_ready_after");
    repeat (3) @(negedge clk);
    check("ff_frame_bits", 32'(bits), 32'h3FF);
    check("ff_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("ff_err_pulses", 32'(err_cnt - e0), 32'd0);

    // tx_valid held high: one frame per IDLE acceptance; glitch on the clock ignored
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    fork
      begin
        dev_receive(1'b1, 11, 3, bits);
        dev_receive(1'b1, 11, 0, bits2);
      end
      begin
        n = 0;
        while (acc_cnt < a0 + 1 && n < 3 * int'(TO)) begin
          @(negedge clk);
          n++;
        end
        tx_data = 8'hA5;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 3 * int'(TO)) begin
          @(negedge clk);
          n++;
        end
        tx_valid = 1'b0;
      end
    join
    tx_valid = 1'b0;
    wait_ready("hold_ready_after");
    repeat (50) @(negedge clk);
    check("hold_frame1_bits", 32'(bits), 32'h35A);
    check("hold_frame2_bits", 32'(bits2), 32'h3A5);
    check("hold_acceptances", 32'(acc_cnt - a0), 32'd2);
    check("hold_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("hold_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("done_err_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
